// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid bit and bubble/hold counters.
// Optional flush port enabled by defining PIPE_FLUSH_EN.
module pipe_stage_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 8,
  parameter int STALL_W    = 6,
  parameter int STAGE      = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STALL_W-1:0]    stall,
`ifdef PIPE_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic                  in_valid,
  input  logic [REG_ADDR_W-1:0] in_wd,
  input  logic                  in_wreg,
  input  logic [DATA_W-1:0]     in_wdata,
  input  logic [DATA_W-1:0]     in_hi,
  input  logic [DATA_W-1:0]     in_lo,
  input  logic                  in_whilo,
  input  logic [ALUOP_W-1:0]    in_aluop,
  input  logic [DATA_W-1:0]     in_mem_addr,
  input  logic [DATA_W-1:0]     in_reg2,
  input  logic                  in_cp0_we,
  input  logic [4:0]            in_cp0_waddr,
  input  logic [DATA_W-1:0]     in_cp0_data,
  output logic                  out_valid,
  output logic [REG_ADDR_W-1:0] out_wd,
  output logic                  out_wreg,
  output logic [DATA_W-1:0]     out_wdata,
  output logic [DATA_W-1:0]     out_hi,
  output logic [DATA_W-1:0]     out_lo,
  output logic                  out_whilo,
  output logic [ALUOP_W-1:0]    out_aluop,
  output logic [DATA_W-1:0]     out_mem_addr,
  output logic [DATA_W-1:0]     out_reg2,
  output logic                  out_cp0_we,
  output logic [4:0]            out_cp0_waddr,
  output logic [DATA_W-1:0]     out_cp0_data,
  output logic [CNT_W-1:0]      bubble_cnt,
  output logic [CNT_W-1:0]      hold_cnt
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] wd;
    logic                  wreg;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W-1:0]     hi;
    logic [DATA_W-1:0]     lo;
    logic                  whilo;
    logic [ALUOP_W-1:0]    aluop;
    logic [DATA_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     reg2;
    logic                  cp0_we;
    logic [4:0]            cp0_waddr;
    logic [DATA_W-1:0]     cp0_data;
  } pl_t;

  pl_t  pl_d;
  pl_t  pl_q;
  logic s_up;
  logic s_dn;
  logic kill;
  logic a_bub;
  logic a_adv;
  logic a_hold;

  assign s_up = stall[STAGE];
  assign s_dn = stall[STAGE+1];

  // Actions are made mutually exclusive so the decoder below is one-hot.
`ifdef PIPE_FLUSH_EN
  logic a_flush;
  assign a_flush = !rst && flush;
  assign kill    = rst || flush;
`else
  assign kill    = rst;
`endif

  assign a_bub  = !kill && s_up && !s_dn;
  assign a_adv  = !kill && !s_up;
  assign a_hold = !kill && s_up && s_dn;

  always_comb begin
    pl_d           = '0;
    pl_d.valid     = in_valid;
    pl_d.wd        = in_wd;
    pl_d.wreg      = in_wreg;
    pl_d.wdata     = in_wdata;
    pl_d.hi        = in_hi;
    pl_d.lo        = in_lo;
    pl_d.whilo     = in_whilo;
    pl_d.aluop     = in_aluop;
    pl_d.mem_addr  = in_mem_addr;
    pl_d.reg2      = in_reg2;
    pl_d.cp0_we    = in_cp0_we;
    pl_d.cp0_waddr = in_cp0_waddr;
    pl_d.cp0_data  = in_cp0_data;
  end

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] c
  );
    return (&c) ? c : c + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    unique case (1'b1)
      rst: begin
        pl_q       <= '0;
        bubble_cnt <= '0;
        hold_cnt   <= '0;
      end
`ifdef PIPE_FLUSH_EN
      a_flush: pl_q <= '0;
`endif
      a_bub: begin
        pl_q       <= '0;
        bubble_cnt <= sat_inc(bubble_cnt);
      end
      a_adv:  pl_q     <= pl_d;
      a_hold: hold_cnt <= sat_inc(hold_cnt);
      default: ;
    endcase
  end

  assign out_valid     = pl_q.valid;
  assign out_wd        = pl_q.wd;
  assign out_wreg      = pl_q.wreg;
  assign out_wdata     = pl_q.wdata;
  assign out_hi        = pl_q.hi;
  assign out_lo        = pl_q.lo;
  assign out_whilo     = pl_q.whilo;
  assign out_aluop     = pl_q.aluop;
  assign out_mem_addr  = pl_q.mem_addr;
  assign out_reg2      = pl_q.reg2;
  assign out_cp0_we    = pl_q.cp0_we;
  assign out_cp0_waddr = pl_q.cp0_waddr;
  assign out_cp0_data  = pl_q.cp0_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg; a CNT_W=2 copy shares the stimulus.
// Builds with or without PIPE_FLUSH_EN.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        in_valid, in_wreg, in_whilo, in_cp0_we;
  logic [4:0]  in_wd, in_cp0_waddr;
  logic [31:0] in_wdata, in_hi, in_lo, in_mem_addr;
  logic [31:0] in_reg2, in_cp0_data;
  logic [7:0]  in_aluop;

  logic        out_valid, out_wreg, out_whilo, out_cp0_we;
  logic [4:0]  out_wd, out_cp0_waddr;
  logic [31:0] out_wdata, out_hi, out_lo, out_mem_addr;
  logic [31:0] out_reg2, out_cp0_data;
  logic [7:0]  out_aluop;
  logic [15:0] bubble_cnt, hold_cnt;

  logic        s_valid, s_wreg, s_whilo, s_cp0_we;
  logic [4:0]  s_wd, s_cp0_waddr;
  logic [31:0] s_wdata, s_hi, s_lo, s_mem_addr;
  logic [31:0] s_reg2, s_cp0_data;
  logic [7:0]  s_aluop;
  logic [1:0]  s_bubble, s_hold;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .rst(rst), .stall(stall),
`ifdef PIPE_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid), .in_wd(in_wd), .in_wreg(in_wreg),
    .in_wdata(in_wdata), .in_hi(in_hi), .in_lo(in_lo),
    .in_whilo(in_whilo), .in_aluop(in_aluop),
    .in_mem_addr(in_mem_addr), .in_reg2(in_reg2),
    .in_cp0_we(in_cp0_we), .in_cp0_waddr(in_cp0_waddr),
    .in_cp0_data(in_cp0_data),
    .out_valid(out_valid), .out_wd(out_wd), .out_wreg(out_wreg),
    .out_wdata(out_wdata), .out_hi(out_hi), .out_lo(out_lo),
    .out_whilo(out_whilo), .out_aluop(out_aluop),
    .out_mem_addr(out_mem_addr), .out_reg2(out_reg2),
    .out_cp0_we(out_cp0_we), .out_cp0_waddr(out_cp0_waddr),
    .out_cp0_data(out_cp0_data),
    .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
  );

  pipe_stage_reg #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .stall(stall),
`ifdef PIPE_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid), .in_wd(in_wd), .in_wreg(in_wreg),
    .in_wdata(in_wdata), .in_hi(in_hi), .in_lo(in_lo),
    .in_whilo(in_whilo), .in_aluop(in_aluop),
    .in_mem_addr(in_mem_addr), .in_reg2(in_reg2),
    .in_cp0_we(in_cp0_we), .in_cp0_waddr(in_cp0_waddr),
    .in_cp0_data(in_cp0_data),
    .out_valid(s_valid), .out_wd(s_wd), .out_wreg(s_wreg),
    .out_wdata(s_wdata), .out_hi(s_hi), .out_lo(s_lo),
    .out_whilo(s_whilo), .out_aluop(s_aluop),
    .out_mem_addr(s_mem_addr), .out_reg2(s_reg2),
    .out_cp0_we(s_cp0_we), .out_cp0_waddr(s_cp0_waddr),
    .out_cp0_data(s_cp0_data),
    .bubble_cnt(s_bubble), .hold_cnt(s_hold)
  );

  typedef struct {
    string       n;
    logic        v;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [7:0]  aluop;
    logic [31:0] maddr;
    logic        cwe;
    logic [4:0]  cwa;
    logic [31:0] side;
    logic [15:0] b;
    logic [15:0] h;
    logic [1:0]  sb;
    logic [1:0]  sh;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk(
    input string n, input logic v, input logic [4:0] wd,
    input logic wreg, input logic [31:0] wdata,
    input logic [7:0] aluop, input logic [31:0] maddr,
    input logic cwe, input logic [4:0] cwa,
    input logic [31:0] side, input logic [15:0] b,
    input logic [15:0] h, input logic [1:0] sb,
    input logic [1:0] sh
  );
    exp_t e;
    e.n = n; e.v = v; e.wd = wd; e.wreg = wreg;
    e.wdata = wdata; e.aluop = aluop; e.maddr = maddr;
    e.cwe = cwe; e.cwa = cwa; e.side = side;
    e.b = b; e.h = h; e.sb = sb; e.sh = sh;
    return e;
  endfunction

  function automatic exp_t mkz(
    input string n, input logic [15:0] b,
    input logic [15:0] h, input logic [1:0] sb,
    input logic [1:0] sh
  );
    return mk(n, 0, 0, 0, 0, 0, 0, 0, 0, 0, b, h, sb, sh);
  endfunction

  task automatic chk(
    input string n, input string f,
    input logic [31:0] a, input logic [31:0] e
  );
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s.%s got %h expected %h", n, f, a, e);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk(e.n, "valid", 32'(out_valid), 32'(e.v));
        chk(e.n, "wd", 32'(out_wd), 32'(e.wd));
        chk(e.n, "wreg", 32'(out_wreg), 32'(e.wreg));
        chk(e.n, "whilo", 32'(out_whilo), 32'(e.wreg));
        chk(e.n, "wdata", out_wdata, e.wdata);
        chk(e.n, "hi", out_hi, e.side);
        chk(e.n, "lo", out_lo, e.side);
        chk(e.n, "reg2", out_reg2, e.side);
        chk(e.n, "cp0_data", out_cp0_data, e.side);
        chk(e.n, "aluop", 32'(out_aluop), 32'(e.aluop));
        chk(e.n, "mem_addr", out_mem_addr, e.maddr);
        chk(e.n, "cp0_we", 32'(out_cp0_we), 32'(e.cwe));
        chk(e.n, "cp0_waddr", 32'(out_cp0_waddr), 32'(e.cwa));
        chk(e.n, "bubble_cnt", 32'(bubble_cnt), 32'(e.b));
        chk(e.n, "hold_cnt", 32'(hold_cnt), 32'(e.h));
        chk(e.n, "sat_valid", 32'(s_valid), 32'(e.v));
        chk(e.n, "sat_bubble", 32'(s_bubble), 32'(e.sb));
        chk(e.n, "sat_hold", 32'(s_hold), 32'(e.sh));
      end
    end
  end

  task automatic drv(
    input logic v, input logic [4:0] wd, input logic wreg,
    input logic [31:0] wdata, input logic [7:0] aluop,
    input logic [31:0] maddr, input logic cwe,
    input logic [4:0] cwa, input logic [31:0] side
  );
    in_valid = v; in_wd = wd; in_wreg = wreg;
    in_whilo = wreg; in_wdata = wdata; in_aluop = aluop;
    in_mem_addr = maddr; in_cp0_we = cwe;
    in_cp0_waddr = cwa; in_hi = side; in_lo = side;
    in_reg2 = side; in_cp0_data = side;
  endtask

  task automatic cyc(input exp_t e);
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [1:0] sat2(input int i);
    return (i > 3) ? 2'd3 : 2'(i);
  endfunction

  initial begin : stim
    rst = 1'b1; stall = '0; flush = 1'b0;
    drv(1, 7, 1, 32'hFFFF_FFFF, 8'h11, 32'h44, 1, 3,
        32'hA5A5_A5A5);
    @(negedge clk);
    cyc(mkz("rst0", 0, 0, 0, 0));
    cyc(mkz("rst1", 0, 0, 0, 0));

    rst = 1'b0;
    drv(1, 5, 1, 32'hDEAD_BEEF, 0, 0, 1, 12, 32'h1111_0000);
    cyc(mk("adv", 1, 5, 1, 32'hDEAD_BEEF, 0, 0, 1, 12,
           32'h1111_0000, 0, 0, 0, 0));

    stall = 6'b100111;
    drv(1, 9, 1, 32'h55, 8'h03, 32'h8, 0, 0, 32'h2222);
    cyc(mk("ignore", 1, 9, 1, 32'h55, 8'h03, 32'h8, 0, 0,
           32'h2222, 0, 0, 0, 0));

    stall = '0;
    drv(1, 2, 1, 32'hAA, 8'h24, 32'h100, 0, 0, 32'h3333);
    cyc(mk("load", 1, 2, 1, 32'hAA, 8'h24, 32'h100, 0, 0,
           32'h3333, 0, 0, 0, 0));

    stall = 6'b001000;
    for (int i = 1; i <= 3; i++)
      cyc(mkz("bubble", 16'(i), 0, sat2(i), 0));

    stall = 6'b011000; rst = 1'b1;
    cyc(mkz("midrst", 0, 0, 0, 0));
    rst = 1'b0;
    cyc(mkz("postrst", 0, 1, 0, 1));

    rst = 1'b1;
    cyc(mkz("satrst", 0, 0, 0, 0));
    rst = 1'b0; stall = 6'b001000;
    for (int i = 1; i <= 5; i++)
      cyc(mkz("sat", 16'(i), 0, sat2(i), 0));

    rst = 1'b1; stall = '0;
    cyc(mkz("holdrst", 0, 0, 0, 0));
    rst = 1'b0;
    drv(1, 4, 1, 32'h1234, 8'h21, 0, 0, 0, 32'h4444);
    cyc(mk("hload", 1, 4, 1, 32'h1234, 8'h21, 0, 0, 0,
           32'h4444, 0, 0, 0, 0));
    stall = 6'b011000;
    for (int i = 1; i <= 4; i++) begin
      drv(0, 5'(i), 0, 32'h9999 + 32'(i), 8'(i), 32'(i), 1,
          5'(i), 32'(i));
      cyc(mk("hold", 1, 4, 1, 32'h1234, 8'h21, 0, 0, 0,
             32'h4444, 0, 16'(i), 0, sat2(i)));
    end

`ifdef PIPE_FLUSH_EN
    flush = 1'b1;
    cyc(mkz("flush", 0, 4, 0, 3));
    flush = 1'b0;
`endif

    stall = '0;
    drv(0, 6, 1, 32'h77, 8'h05, 32'h20, 1, 7, 32'h5555);
    cyc(mk("novalid", 0, 6, 1, 32'h77, 8'h05, 32'h20, 1, 7,
           32'h5555, 0, 4, 0, 3));

    repeat (2) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0",
               sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register; next generation of the EX/MEM latch. Sits between two adjacent pipeline stages (default EX→MEM) and carries the register-file, HI/LO, memory-access and CP0 write payload. It adds a valid bit, an optional flush, and saturating bubble/hold performance counters. Every field, including memory and CP0 fields, is cleared on reset and on bubble insertion.

## Interface
Parameters:
- DATA_W, 32, width of wdata/hi/lo/mem_addr/reg2/cp0_data
- REG_ADDR_W, 5, GPR address width
- ALUOP_W, 8, ALU sub-op width; 0 encodes NOP
- STALL_W, 6, width of stall vector
- STAGE, 3, stall bit of the upstream stage; STAGE+1 is the downstream stage; STAGE+1 < STALL_W required
- CNT_W, 16, performance counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  STALL_W  pipeline stall vector, 1 = stop
- flush  in  1  discard stage contents (present only with PIPE_FLUSH_EN)
- in_valid  in  1  upstream holds a real instruction
- in_wd / in_wreg  in  REG_ADDR_W / 1  GPR destination / write enable
- in_wdata  in  DATA_W  GPR write data
- in_hi, in_lo / in_whilo  in  DATA_W each / 1  HI/LO data / write enable
- in_aluop  in  ALUOP_W  sub-op
- in_mem_addr, in_reg2  in  DATA_W each  access address, store data
- in_cp0_we / in_cp0_waddr / in_cp0_data  in  1 / 5 / DATA_W  CP0 write
- out_*  out  same widths  registered copies of every in_* field, plus out_valid
- bubble_cnt  out  CNT_W  bubbles inserted since reset
- hold_cnt  out  CNT_W  hold cycles since reset

## Operation
- Condition priority each cycle: rst > flush > bubble > advance > hold.
- rst: every output 0, incl. counters; out_aluop = 0 (NOP).
- flush (macro enabled): all out_* and out_valid to 0; counters unchanged.
- bubble (stall[STAGE]=1, stall[STAGE+1]=0): all out_* to 0, out_valid=0; bubble_cnt +1.
- advance (stall[STAGE]=0): every out_* <= in_*, out_valid <= in_valid. Each CP0 field comes from its own input, so out_cp0_we <= in_cp0_we.
- hold (stall[STAGE]=1, stall[STAGE+1]=1): all out_* retained; hold_cnt +1.
- Counters saturate at 2^CNT_W−1 and never wrap.
- stall bits other than STAGE and STAGE+1 are ignored.
- in_valid=0 on advance latches the payload as given. Downstream must gate writes with out_valid.

## Timing
- Latency 1 cycle: inputs sampled on rising edge N appear on outputs after edge N.
- No combinational path from any input to any output.
- Reset asserted mid-stall: outputs and counters zero on that edge. The following edge evaluates normally.
- flush with hold on the same cycle: flush wins; hold_cnt is not incremented.
- Counters update on the same edge as the data action they count.

## Configuration
- PIPE_FLUSH_EN defined: flush port exists and behaves as above.
- PIPE_FLUSH_EN undefined: no flush port, and the flush branch is absent. Priority becomes rst > bubble > advance > hold.

## Test plan
- Reset: drive nonzero inputs with rst=1 for 2 cycles → all outputs 0, bubble_cnt=hold_cnt=0.
- Advance: stall=0, in_wd=5, in_wreg=1, in_wdata=0xDEADBEEF, in_cp0_we=1, in_cp0_waddr=12, in_valid=1 → next edge out_wd=5, out_wdata=0xDEADBEEF, out_cp0_we=1, out_cp0_waddr=12, out_valid=1.
- Bubble: stall=6'b001000 for 3 cycles after a valid load with in_aluop=0x24, in_mem_addr=0x100 → out_valid=0, out_aluop=0, out_mem_addr=0, out_wreg=0; bubble_cnt=3.
- Hold: latch wdata=0x1234, then stall=6'b011000 for 4 cycles while inputs change → out_wdata stays 0x1234, out_valid=1, hold_cnt=4.
- Flush (macro on): flush=1 together with stall=6'b011000 → outputs 0, hold_cnt unchanged. With the macro off the port is absent; build and regress the same bench without it.
- Saturation: CNT_W=2, 5 bubble cycles → bubble_cnt reads 1,2,3,3,3.
